// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port synchronous RAM: port 0 has fixed
// priority, port 1 is protected by a starvation counter that forces a grant.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic              resp_pend_reg;
    logic              resp_owner_reg;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [DATA_W-1:0] wdata_hold_reg;

    logic              force1;
    logic              gnt0, gnt1, any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Reset overrides every request in the same cycle, so grants are gated by rst.
    always_comb begin
        force1    = (wait_cnt_reg == MAX_CNT);
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (!rst) begin
            if (m1_req && force1) begin
                gnt1 = 1'b1;
            end else if (m0_req) begin
                gnt0 = 1'b1;
            end else if (m1_req) begin
                gnt1 = 1'b1;
            end
        end
        any_gnt   = gnt0 | gnt1;
        sel_we    = gnt1 ? m1_we    : m0_we;
        sel_addr  = gnt1 ? m1_addr  : m0_addr;
        sel_wdata = gnt1 ? m1_wdata : m0_wdata;
    end

    always_comb begin
        wait_cnt_next = 4'd0;
        if (m1_req && !gnt1) begin
            wait_cnt_next = force1 ? wait_cnt_reg : wait_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg   <= 4'd0;
            resp_pend_reg  <= 1'b0;
            resp_owner_reg <= 1'b0;
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
        end else begin
            wait_cnt_reg  <= wait_cnt_next;
            resp_pend_reg <= any_gnt && !sel_we;
            if (any_gnt) begin
                resp_owner_reg <= gnt1;
                addr_hold_reg  <= sel_addr;
                wdata_hold_reg <= sel_wdata;
            end
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign mem_en    = any_gnt;
    assign mem_we    = any_gnt && sel_we;
    assign mem_addr  = rst ? '0 : (any_gnt ? sel_addr  : addr_hold_reg);
    assign mem_wdata = rst ? '0 : (any_gnt ? sel_wdata : wdata_hold_reg);

    logic              port_valid [2];
    logic [DATA_W-1:0] port_rdata [2];

    // Each port owns its own read-data holding register; only the owner of
    // the pending response updates it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic [DATA_W-1:0] rdata_hold_reg;

            assign port_valid[gi] = !rst && resp_pend_reg && (resp_owner_reg == 1'(gi));
            assign port_rdata[gi] = rst ? '0 : (port_valid[gi] ? mem_rdata : rdata_hold_reg);

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_hold_reg <= '0;
                end else if (port_valid[gi]) begin
                    rdata_hold_reg <= mem_rdata;
                end
            end
        end
    endgenerate

    assign m0_rvalid = port_valid[0];
    assign m1_rvalid = port_valid[1];
    assign m0_rdata  = port_rdata[0];
    assign m1_rdata  = port_rdata[1];

endmodule
